// File: rtl/enq_feeder_pkg.sv
// rtl/enq_feeder_pkg.sv - shared types, defaults and sizing helper for the enqueue feeder
package enq_feeder_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_t;

  // Bits needed to index `value` distinct items (clog2(1) = 0).
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/enq_feeder_buf.sv
// rtl/enq_feeder_buf.sv - circular buffer with two same-cycle write slots and one read port
module enq_feeder_buf
  import enq_feeder_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = 4,
  parameter int PTR_W    = clog2(DEPTH),
  parameter int CNT_BITS = clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_wr0_en,
  input  logic [DATA_W-1:0]   i_wr0_data,
  input  logic                i_wr1_en,
  input  logic [DATA_W-1:0]   i_wr1_data,
  input  logic                i_rd_en,
  output logic [DATA_W-1:0]   o_rd_data,
  output logic [CNT_BITS-1:0] o_count
);

  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_BITS-1:0] r_count;
  logic [PTR_W-1:0]    w_wr_ptr1;
  logic [1:0]          w_n_wr;

  // Slot 1 is only ever used together with slot 0, so it lands one entry later.
  assign w_wr_ptr1 = r_wr_ptr + PTR_W'(1);
  assign w_n_wr    = {1'b0, i_wr0_en} + {1'b0, i_wr1_en};

  always_ff @(posedge clk) begin
    if (i_wr0_en) r_mem[r_wr_ptr] <= i_wr0_data;
    if (i_wr1_en) r_mem[w_wr_ptr1] <= i_wr1_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_n_wr);
      if (i_rd_en) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count  <= r_count + CNT_BITS'(w_n_wr) - CNT_BITS'(i_rd_en);
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;

endmodule

// File: rtl/enq_feeder.sv
// rtl/enq_feeder.sv - round-robin merge of two put channels into a buffer drained to the YY enqueue port
module enq_feeder
  import enq_feeder_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EN_a_put,
  input  logic [DATA_W-1:0] a_put_data,
  output logic              RDY_a_put,
  input  logic              EN_b_put,
  input  logic [DATA_W-1:0] b_put_data,
  output logic              RDY_b_put,
  input  logic              YY_RDYenq2,
  output logic              YY_ENQsafeToEnqueueOn2,
  output logic              EN_YY_enqueue,
  output logic [DATA_W-1:0] YY_Data,
  output logic [CNT_W-1:0]  sent_count,
  output logic              busy
);

  localparam int CNT_BITS = clog2(DEPTH + 1);

  prio_t               r_prio;
  logic [CNT_W-1:0]    r_sent;
  logic [CNT_BITS-1:0] w_count;
  logic [CNT_BITS-1:0] w_free;
  logic                w_owner_rdy;
  logic                w_other_rdy;
  logic                w_fire_a;
  logic                w_fire_b;
  logic                w_owner_fire;
  logic                w_other_fire;
  logic [DATA_W-1:0]   w_owner_data;
  logic [DATA_W-1:0]   w_other_data;
  logic                w_wr0_en;
  logic [DATA_W-1:0]   w_wr0_data;
  logic                w_wr1_en;
  logic                w_nonempty;
  logic                w_deq;
  logic [DATA_W-1:0]   w_head;

  // Readiness comes only from registered count, so a same-cycle drain never frees space early.
  assign w_free      = CNT_BITS'(DEPTH) - w_count;
  assign w_owner_rdy = (w_free >= CNT_BITS'(1));
  assign w_other_rdy = (w_free >= CNT_BITS'(2));

  always_comb begin
    RDY_a_put    = 1'b0;
    RDY_b_put    = 1'b0;
    w_owner_fire = 1'b0;
    w_other_fire = 1'b0;
    w_owner_data = '0;
    w_other_data = '0;
    w_fire_a     = 1'b0;
    w_fire_b     = 1'b0;
    if (r_prio == PRIO_A) begin
      RDY_a_put    = w_owner_rdy;
      RDY_b_put    = w_other_rdy;
      w_fire_a     = EN_a_put & RDY_a_put;
      w_fire_b     = EN_b_put & RDY_b_put;
      w_owner_fire = w_fire_a;
      w_other_fire = w_fire_b;
      w_owner_data = a_put_data;
      w_other_data = b_put_data;
    end else begin
      RDY_a_put    = w_other_rdy;
      RDY_b_put    = w_owner_rdy;
      w_fire_a     = EN_a_put & RDY_a_put;
      w_fire_b     = EN_b_put & RDY_b_put;
      w_owner_fire = w_fire_b;
      w_other_fire = w_fire_a;
      w_owner_data = b_put_data;
      w_other_data = a_put_data;
    end
  end

  // Owner's word is always written first; a lone non-owner word takes slot 0.
  assign w_wr0_en   = w_owner_fire | w_other_fire;
  assign w_wr0_data = w_owner_fire ? w_owner_data : w_other_data;
  assign w_wr1_en   = w_owner_fire & w_other_fire;

  assign w_nonempty             = (w_count != '0);
  assign w_deq                  = w_nonempty & YY_RDYenq2;
  assign EN_YY_enqueue          = w_deq;
  assign YY_ENQsafeToEnqueueOn2 = w_deq;
  assign YY_Data                = w_nonempty ? w_head : '0;
  assign busy                   = w_nonempty;
  assign sent_count             = r_sent;

  enq_feeder_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_buf (
    .clk        (CLK),
    .rst_n      (RST_N),
    .i_wr0_en   (w_wr0_en),
    .i_wr0_data (w_wr0_data),
    .i_wr1_en   (w_wr1_en),
    .i_wr1_data (w_other_data),
    .i_rd_en    (w_deq),
    .o_rd_data  (w_head),
    .o_count    (w_count)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_prio <= PRIO_A;
      r_sent <= '0;
    end else begin
      if (w_owner_fire) r_prio <= (r_prio == PRIO_A) ? PRIO_B : PRIO_A;
      if (w_deq) r_sent <= r_sent + CNT_W'(1);
    end
  end

  a_put_legal: assert property (@(posedge CLK) disable iff (!RST_N) EN_a_put |-> RDY_a_put);
  b_put_legal: assert property (@(posedge CLK) disable iff (!RST_N) EN_b_put |-> RDY_b_put);

endmodule
